// File: rtl/tiny_vga_pkg.sv
// Shared timing defaults, pixel type and the Tiny VGA PMOD pin packing for tiny_vga_out.
package tiny_vga_pkg;

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_FP         = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BP         = 48;
    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_FP         = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BP         = 33;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    // hs/vs are pin levels, polarity already applied by the caller.
    function automatic logic [7:0] pack_tinyvga(input rgb222_t c, input logic hs, input logic vs);
        return {hs, c.b[0], c.g[0], c.r[0], vs, c.b[1], c.g[1], c.r[1]};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA timing axis: wrapping position counter plus active/sync region decode.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    output logic [9:0] count_o,
    output logic       wrap_o,
    output logic       in_active_o,
    output logic       in_sync_o
);

    localparam int         TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam logic [9:0] LAST    = 10'(TOTAL - 1);
    localparam logic [9:0] ACT_END = 10'(ACTIVE);
    localparam logic [9:0] SYNC_LO = 10'(ACTIVE + FP);
    localparam logic [9:0] SYNC_HI = 10'(ACTIVE + FP + SYNC - 1);

    if (TOTAL > 1024 || TOTAL < 2) begin : g_bad_total
        $error("vga_axis_counter: TOTAL must be in 2..1024");
    end

    logic [9:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = wrap_o ? 10'd0 : count_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 10'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign wrap_o      = (count_q == LAST);
    assign in_active_o = (count_q < ACT_END);
    assign in_sync_o   = (count_q >= SYNC_LO) && (count_q <= SYNC_HI);

endmodule

// File: rtl/tiny_vga_out.sv
// VGA timing generator with clock-enable pixel divider, driving the Tiny VGA PMOD on uo_out.
module tiny_vga_out
    import tiny_vga_pkg::*;
#(
    parameter int CLK_DIV  = 5,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [5:0] rgb_i,
    output logic       pix_en_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       active_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic [7:0] uo_out
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [7:0]    UO_IDLE  = pack_tinyvga(rgb222_t'(6'd0), SYNC_NEG, SYNC_NEG);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("tiny_vga_out: CLK_DIV must be >= 1");
    end

    logic [DW-1:0] div_q, div_d;
    logic [7:0]    uo_q, uo_d;
    logic          h_wrap, h_active, h_sync;
    logic          v_active, v_sync;
    rgb222_t       pix;

    assign pix_en_o = ena && (div_q == DIV_LAST);

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (pix_en_o),
        .count_o    (x_o),
        .wrap_o     (h_wrap),
        .in_active_o(h_active),
        .in_sync_o  (h_sync)
    );

    // The vertical wrap flag is not needed: y wraps on the same strobe as x.
    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (h_wrap && pix_en_o),
        .count_o    (y_o),
        .wrap_o     (),
        .in_active_o(v_active),
        .in_sync_o  (v_sync)
    );

    assign active_o      = h_active && v_active;
    assign line_start_o  = pix_en_o && (x_o == 10'd0);
    assign frame_start_o = line_start_o && (y_o == 10'd0);
    assign pix           = active_o ? rgb222_t'(rgb_i) : rgb222_t'(6'd0);

    always_comb begin
        div_d = div_q;
        uo_d  = uo_q;
        if (!ena) begin
            uo_d = UO_IDLE;
        end else begin
            div_d = pix_en_o ? '0 : div_q + DW'(1);
            if (pix_en_o) begin
                uo_d = pack_tinyvga(pix, h_sync ^ SYNC_NEG, v_sync ^ SYNC_NEG);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            uo_q  <= UO_IDLE;
        end else begin
            div_q <= div_d;
            uo_q  <= uo_d;
        end
    end

    assign uo_out = uo_q;

endmodule

// File: tb/tb_tiny_vga_out.sv
// Randomized bench for tiny_vga_out on a shrunken raster, checked against a strobe-count reference model.
module tb_tiny_vga_out;

    localparam int D  = 3;
    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic [7:0] IDLE = 8'h88;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [5:0] rgb_i = 6'd0;
    logic       pix_en_o, active_o, line_start_o, frame_start_o;
    logic [9:0] x_o, y_o;
    logic [7:0] uo_out;

    always #5 clk = ~clk;

    tiny_vga_out #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_NEG(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .rgb_i        (rgb_i),
        .pix_en_o     (pix_en_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .active_o     (active_o),
        .line_start_o (line_start_o),
        .frame_start_o(frame_start_o),
        .uo_out       (uo_out)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pix_en;
        logic       active;
        logic       ls;
        logic       fs;
        logic [7:0] uo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: position is just the number of enabled clocks since reset.
    int         en_cnt = 0;
    logic [7:0] uo_m = IDLE;

    function automatic int cur_x();
        return (en_cnt / D) % HT;
    endfunction

    function automatic int cur_y();
        return ((en_cnt / D) / HT) % VT;
    endfunction

    function automatic logic [7:0] model_pack(input logic [5:0] c, input logic hs_on, input logic vs_on);
        logic [7:0] b;
        b[7] = !hs_on;
        b[6] = c[0];
        b[5] = c[2];
        b[4] = c[4];
        b[3] = !vs_on;
        b[2] = c[1];
        b[1] = c[3];
        b[0] = c[5];
        return b;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [5:0] c);
        int   x, y;
        logic strobe, vis;
        exp_t ex;
        rst   = r;
        ena   = e;
        rgb_i = c;
        x      = cur_x();
        y      = cur_y();
        vis    = (x < HA) && (y < VA);
        strobe = e && ((en_cnt % D) == D - 1);
        ex.x      = 10'(x);
        ex.y      = 10'(y);
        ex.pix_en = strobe;
        ex.active = vis;
        ex.ls     = strobe && (x == 0);
        ex.fs     = strobe && (x == 0) && (y == 0);
        ex.uo     = uo_m;
        exp_q.push_back(ex);
        if (r) begin
            en_cnt = 0;
            uo_m   = IDLE;
        end else if (!e) begin
            uo_m = IDLE;
        end else begin
            if (strobe) begin
                uo_m = model_pack(vis ? c : 6'd0,
                                  (x >= HA + HF) && (x < HA + HF + HS),
                                  (y >= VA + VF) && (y < VA + VF + VS));
            end
            en_cnt = (en_cnt + 1) % (HT * VT * D);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("x_o",           x_o,                   mon_e.x);
            check("y_o",           y_o,                   mon_e.y);
            check("pix_en_o",      10'(pix_en_o),         10'(mon_e.pix_en));
            check("active_o",      10'(active_o),         10'(mon_e.active));
            check("line_start_o",  10'(line_start_o),     10'(mon_e.ls));
            check("frame_start_o", 10'(frame_start_o),    10'(mon_e.fs));
            check("uo_out",        10'(uo_out),           10'(mon_e.uo));
        end
    end

    initial begin
        logic [5:0] c;
        int         guard;
        rst = 1'b1;
        ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en_cnt = 0;
        uo_m   = IDLE;

        // Two full frames free running, with the known colour at (10,5).
        for (int i = 0; i < 2 * HT * VT * D + 100; i++) begin
            c = (cur_x() == 10 && cur_y() == 5) ? 6'b10_01_11 : 6'($urandom_range(0, 63));
            step(1'b0, 1'b1, c);
        end

        // Reset pulse mid-frame, then a 20-clock enable drop after some progress.
        guard = 0;
        while (!(cur_x() == 6 && cur_y() == 7) && guard < HT * VT * D + 10) begin
            step(1'b0, 1'b1, 6'($urandom_range(0, 63)));
            guard++;
        end
        check("reach_x6_y7", 10'(guard < HT * VT * D + 10), 10'd1);
        step(1'b1, 1'b1, 6'h3F);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 6'($urandom_range(0, 63)));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 6'h3F);

        // Random enable gaps and rare resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'b0 || ($urandom_range(0, 399) == 0),
                 $urandom_range(0, 7) != 0,
                 6'($urandom_range(0, 63)));
        end

        @(negedge clk);
        #1;
        check("queue_drain", 10'(exp_q.size()), 10'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
